// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/HALT control, next-PC selection with
// trap/stall/branch/return priority, misaligned-target detection and a
// circular return-address stack (RAS) that overwrites its oldest entry when full.
module pc_sequencer #(
  parameter int          XLEN         = 32,
  parameter logic [63:0] RESET_VECTOR = 64'h0,
  parameter logic [63:0] TRAP_VECTOR  = 64'h100,
  parameter int          RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            trap,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            is_compressed,
  input  logic            ras_push,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc_current,
  output logic            pc_valid,
  output logic            misaligned,
  output logic            halted,
  output logic            ras_empty
);

  localparam int PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CntW = PtrW + 1;
  localparam logic [XLEN-1:0] ResetPc = RESET_VECTOR[XLEN-1:0];
  localparam logic [XLEN-1:0] TrapPc  = TRAP_VECTOR[XLEN-1:0];
  localparam logic [CntW-1:0] FullCnt = CntW'(RAS_DEPTH);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misaligned_q, misaligned_d;
  logic [PtrW-1:0] top_q, top_d;
  logic [CntW-1:0] count_q, count_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];

  logic            ras_we;
  logic [PtrW-1:0] ras_waddr;
  logic [XLEN-1:0] inc;
  logic [XLEN-1:0] ret_addr;
  logic            ras_has;
  logic            pop_eff;

  assign inc      = is_compressed ? XLEN'(2) : XLEN'(4);
  assign ret_addr = pc_q + inc;
  assign ras_has  = (count_q != '0);
  // A taken branch suppresses the pop; a pop on an empty stack does nothing.
  assign pop_eff  = ras_pop && ras_has && !branch_taken;

  // Next-state, next-PC and RAS pointer/write selection.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    misaligned_d = 1'b0;
    top_d        = top_q;
    count_d      = count_q;
    ras_we       = 1'b0;
    ras_waddr    = top_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (trap) begin
          pc_d = TrapPc;
        end else if (!stall) begin
          if (halt_req) begin
            state_d = HALT;
          end else begin
            if (branch_taken) begin
              if (branch_target[0]) begin
                pc_d         = TrapPc;
                misaligned_d = 1'b1;
              end else begin
                pc_d = branch_target;
              end
            end else if (pop_eff) begin
              pc_d = ras_q[top_q];
            end else begin
              pc_d = ret_addr;
            end

            if (pop_eff && ras_push) begin
              ras_we    = 1'b1;
              ras_waddr = top_q;
            end else if (pop_eff) begin
              top_d   = top_q - PtrW'(1);
              count_d = count_q - CntW'(1);
            end else if (ras_push) begin
              ras_we    = 1'b1;
              ras_waddr = top_q + PtrW'(1);
              top_d     = top_q + PtrW'(1);
              count_d   = (count_q == FullCnt) ? count_q : count_q + CntW'(1);
            end
          end
        end
      end
      HALT: begin
        if (trap) begin
          pc_d    = TrapPc;
          state_d = RUN;
        end else if (!stall && resume && !halt_req) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // Control and PC registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= ResetPc;
      misaligned_q <= 1'b0;
      top_q        <= '1;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
      top_q        <= top_d;
      count_q      <= count_d;
    end
  end

  // Return-address storage; contents are meaningless until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (ras_we) begin
      ras_q[ras_waddr] <= ret_addr;
    end
  end

  assign pc_current = pc_q;
  assign pc_valid   = (state_q == RUN);
  assign halted     = (state_q == HALT);
  assign misaligned = misaligned_q;
  assign ras_empty  = (count_q == '0);

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the PC and target width in bits (legal values 32 and 64).
REQ-002 The block SHALL have parameter RESET_VECTOR, default 0, giving the first fetch address after reset.
REQ-003 The block SHALL have parameter TRAP_VECTOR, default 'h100, giving the redirect address on trap or misaligned target.
REQ-004 The block SHALL have parameter RAS_DEPTH, default 4, giving the return-address-stack entry count (power of two, at least 2).
REQ-005 The block SHALL have the following ports:
- clk  in  1  clock; reset is asynchronous, active-high
- reset  in  1  asynchronous active-high reset
- stall  in  1  hold PC and RAS
- halt_req  in  1  enter HALT
- resume  in  1  leave HALT
- trap  in  1  redirect to TRAP_VECTOR
- branch_taken  in  1  redirect to branch_target
- branch_target  in  XLEN  branch or jump destination
- is_compressed  in  1  current instruction is 16-bit
- ras_push  in  1  call: push return address
- ras_pop  in  1  return: redirect to RAS top
- pc_current  out  XLEN  current fetch PC
- pc_valid  out  1  pc_current is a real fetch address
- misaligned  out  1  one-cycle flag: rejected branch_target
- halted  out  1  FSM in HALT
- ras_empty  out  1  RAS holds no entries

Function
REQ-006 The FSM SHALL have states BOOT, RUN and HALT, and SHALL transition BOOT->RUN unconditionally after one cycle.
REQ-007 In BOOT, pc_current SHALL equal RESET_VECTOR and pc_valid SHALL be 0.
REQ-008 In RUN, pc_valid SHALL be 1.
REQ-009 In RUN, the sequential increment SHALL be 2 when is_compressed=1 and 4 otherwise.
REQ-010 All PC arithmetic SHALL wrap modulo 2^XLEN, with no overflow flag.
REQ-011 In RUN, the next-PC priority SHALL be: trap > stall (hold) > branch_taken > ras_pop (RAS non-empty) > sequential.
REQ-012 trap SHALL redirect to TRAP_VECTOR even while stall=1; RAS contents SHALL be unchanged on trap.
REQ-013 If branch_taken=1 and branch_target[0]=1, next PC SHALL be TRAP_VECTOR and misaligned SHALL pulse 1 for exactly the following cycle.
REQ-014 While stall=1 and trap=0, pc_current, the RAS and the FSM state SHALL hold, and ras_push and ras_pop SHALL be ignored.
REQ-015 ras_push SHALL store pc_current+increment into the RAS.
REQ-016 A push to a full RAS SHALL overwrite the oldest entry as a circular buffer, with occupancy saturating at RAS_DEPTH.
REQ-017 ras_pop SHALL redirect to the top entry and decrement occupancy.
REQ-018 ras_pop on an empty RAS SHALL cause no redirect (sequential PC) and no pointer change.
REQ-019 Simultaneous ras_push and ras_pop SHALL redirect to the old top and replace the top with the new return address, with occupancy unchanged.
REQ-020 When branch_taken=1 and ras_pop=1 together, the branch SHALL win and the pop SHALL be suppressed; a simultaneous ras_push SHALL still occur.
REQ-021 halt_req in RUN with trap=0 SHALL enter HALT next cycle with pc_current held; halted SHALL be 1 and pc_valid SHALL be 0 in HALT.
REQ-022 In HALT, resume SHALL return to RUN with the held PC; trap SHALL return to RUN at TRAP_VECTOR; halt_req and resume asserted together SHALL stay in HALT.
REQ-023 ras_empty SHALL be 1 exactly when occupancy is 0.

Reset
REQ-024 reset SHALL asynchronously force state=BOOT, pc_current=RESET_VECTOR, pc_valid=0, misaligned=0, halted=0, RAS occupancy=0 and ras_empty=1, regardless of any in-progress operation.
REQ-025 RAS storage contents need not be cleared by reset.
REQ-026 The first post-reset clock edge SHALL produce RUN with pc_current=RESET_VECTOR.

Verification
REQ-027 The bench SHALL cover: reset, then 3 idle cycles with is_compressed=0,0,1 -> pc_current 0,0(BOOT),4,8 then +2 (0xA); pc_valid 0 then 1.
REQ-028 The bench SHALL cover: push at PC 0x20 (4-byte instruction), branch to 0x80, pop -> redirect to 0x24, ras_empty returns to 1.
REQ-029 The bench SHALL cover: 5 pushes with RAS_DEPTH=4 then 5 pops -> 4 redirects (newest first, oldest lost), 5th pop sequential.
REQ-030 The bench SHALL cover: branch_taken with target 0x41 -> pc_current=0x100, misaligned high exactly one cycle.
REQ-031 The bench SHALL cover: stall=1 with trap=1 -> pc_current=0x100 next cycle; stall alone holds PC and ignores push.
REQ-032 The bench SHALL cover: reset asserted mid-RUN between clock edges -> outputs reach reset values before the next edge; PC=0xFFFFFFFC with +4 -> wraps to 0.
